// File: rtl/ldst_mem_access_pkg.sv
// Shared definitions for the load/store memory access block: access sizes,
// exception codes, FSM state encoding and the misalignment predicate.
package ldst_mem_access_pkg;

    localparam int SIZE_DATA      = 32;
    localparam int LDST_TYPES_LOG = 2;

    localparam logic [LDST_TYPES_LOG-1:0] LDST_BYTE      = 2'd0;
    localparam logic [LDST_TYPES_LOG-1:0] LDST_HALF_WORD = 2'd1;
    localparam logic [LDST_TYPES_LOG-1:0] LDST_WORD      = 2'd2;

    localparam logic [1:0] EXC_OK       = 2'b00;
    localparam logic [1:0] EXC_MISALIGN = 2'b01;
    localparam logic [1:0] EXC_TIMEOUT  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Size encoding 3 behaves as a word access.
    function automatic logic is_misaligned(input logic [LDST_TYPES_LOG-1:0] size,
                                           input logic [1:0] addr_lo);
        logic mis;
        case (size)
            LDST_BYTE:      mis = 1'b0;
            LDST_HALF_WORD: mis = addr_lo[0];
            default:        mis = |addr_lo;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/ldst_lane_align.sv
// Combinational little-endian lane steering: byte enables and replicated
// store data on the way out, lane select plus zero/sign extension on the way in.
module ldst_lane_align
    import ldst_mem_access_pkg::*;
(
    input  logic [1:0]                addr_lo_i,
    input  logic [LDST_TYPES_LOG-1:0] size_i,
    input  logic                      signed_i,
    input  logic [SIZE_DATA-1:0]      store_data_i,
    input  logic [SIZE_DATA-1:0]      rdata_i,
    output logic [3:0]                be_o,
    output logic [SIZE_DATA-1:0]      wdata_o,
    output logic [SIZE_DATA-1:0]      load_data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel    = rdata_i[{addr_lo_i, 3'b000} +: 8];
        half_sel    = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        be_o        = 4'b1111;
        wdata_o     = store_data_i;
        load_data_o = rdata_i;
        // Low address bits below the access size are ignored (forced alignment).
        case (size_i)
            LDST_BYTE: begin
                be_o        = 4'b0001 << addr_lo_i;
                wdata_o     = {4{store_data_i[7:0]}};
                load_data_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
            end
            LDST_HALF_WORD: begin
                be_o        = 4'b0011 << {addr_lo_i[1], 1'b0};
                wdata_o     = {2{store_data_i[15:0]}};
                load_data_o = {{16{signed_i & half_sel[15]}}, half_sel};
            end
            default: begin
                be_o        = 4'b1111;
                wdata_o     = store_data_i;
                load_data_o = rdata_i;
            end
        endcase
    end

endmodule

// File: rtl/ldst_mem_access.sv
// Load/store memory access unit: one outstanding request, bounded wait for ack.
// Define LDST_MISALIGN_TRAP_EN to trap misaligned half/word accesses with exc=01.
module ldst_mem_access
    import ldst_mem_access_pkg::*;
#(
    parameter int TAG_W          = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [SIZE_DATA-1:0]      addr_i,
    input  logic [LDST_TYPES_LOG-1:0] ldstSize_i,
    input  logic                      isStore_i,
    input  logic                      signed_i,
    input  logic [SIZE_DATA-1:0]      storeData_i,
    input  logic [TAG_W-1:0]          tag_i,
    output logic                      mem_req_o,
    output logic                      mem_we_o,
    output logic [SIZE_DATA-1:0]      mem_addr_o,
    output logic [3:0]                mem_be_o,
    output logic [SIZE_DATA-1:0]      mem_wdata_o,
    input  logic                      mem_ack_i,
    input  logic [SIZE_DATA-1:0]      mem_rdata_i,
    output logic                      resp_valid_o,
    input  logic                      resp_ready_i,
    output logic [SIZE_DATA-1:0]      resp_data_o,
    output logic [TAG_W-1:0]          resp_tag_o,
    output logic [1:0]                resp_exc_o,
    output logic [1:0]                dbg_state_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_e                    state_q;
    logic [SIZE_DATA-1:0]      addr_q;
    logic [SIZE_DATA-1:0]      sdata_q;
    logic [LDST_TYPES_LOG-1:0] size_q;
    logic                      store_q;
    logic                      signed_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [SIZE_DATA-1:0]      resp_data_q;
    logic [TAG_W-1:0]          resp_tag_q;
    logic [1:0]                resp_exc_q;

    logic [3:0]           lane_be;
    logic [SIZE_DATA-1:0] lane_wdata;
    logic [SIZE_DATA-1:0] lane_load;

    ldst_lane_align u_lane (
        .addr_lo_i    (addr_q[1:0]),
        .size_i       (size_q),
        .signed_i     (signed_q),
        .store_data_i (sdata_q),
        .rdata_i      (mem_rdata_i),
        .be_o         (lane_be),
        .wdata_o      (lane_wdata),
        .load_data_o  (lane_load)
    );

    // Valid/ready: a transfer happens on a rising edge where both are high;
    // valid holds with its payload stable until that edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            sdata_q     <= '0;
            size_q      <= '0;
            store_q     <= 1'b0;
            signed_q    <= 1'b0;
            cnt_q       <= '0;
            resp_data_q <= '0;
            resp_tag_q  <= '0;
            resp_exc_q  <= EXC_OK;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        addr_q      <= addr_i;
                        sdata_q     <= storeData_i;
                        size_q      <= ldstSize_i;
                        store_q     <= isStore_i;
                        signed_q    <= signed_i;
                        cnt_q       <= '0;
                        resp_tag_q  <= tag_i;
                        resp_data_q <= '0;
                        resp_exc_q  <= EXC_OK;
`ifdef LDST_MISALIGN_TRAP_EN
                        if (is_misaligned(ldstSize_i, addr_i[1:0])) begin
                            resp_exc_q <= EXC_MISALIGN;
                            state_q    <= ST_RESP;
                        end else begin
                            state_q    <= ST_MEM;
                        end
`else
                        state_q     <= ST_MEM;
`endif
                    end
                end
                ST_MEM: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    // An ack arriving on the expiry cycle still completes normally.
                    if (mem_ack_i) begin
                        resp_data_q <= store_q ? '0 : lane_load;
                        resp_exc_q  <= EXC_OK;
                        state_q     <= ST_RESP;
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        resp_data_q <= '0;
                        resp_exc_q  <= EXC_TIMEOUT;
                        state_q     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_ready_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready_o  = (state_q == ST_IDLE);
    assign mem_req_o    = (state_q == ST_MEM);
    assign mem_we_o     = mem_req_o & store_q;
    assign mem_addr_o   = {addr_q[SIZE_DATA-1:2], 2'b00};
    assign mem_be_o     = mem_req_o ? lane_be : 4'b0000;
    assign mem_wdata_o  = lane_wdata;
    assign resp_valid_o = (state_q == ST_RESP);
    assign resp_data_o  = resp_data_q;
    assign resp_tag_o   = resp_tag_q;
    assign resp_exc_o   = resp_exc_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_ldst_mem_access.sv
// Scoreboard bench for ldst_mem_access: driver, memory responder and response
// monitor run as separate processes against a behavioural reference model.
module tb_ldst_mem_access;

    localparam int TAG_W  = 8;
    localparam int TO     = 64;
    localparam int RESP_W = 32 + TAG_W + 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req_valid_i = 1'b0;
    logic              req_ready_o;
    logic [31:0]       addr_i = '0;
    logic [1:0]        ldstSize_i = '0;
    logic              isStore_i = 1'b0;
    logic              signed_i = 1'b0;
    logic [31:0]       storeData_i = '0;
    logic [TAG_W-1:0]  tag_i = '0;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [31:0]       mem_addr_o;
    logic [3:0]        mem_be_o;
    logic [31:0]       mem_wdata_o;
    logic              mem_ack_i = 1'b0;
    logic [31:0]       mem_rdata_i = '0;
    logic              resp_valid_o;
    logic              resp_ready_i = 1'b0;
    logic [31:0]       resp_data_o;
    logic [TAG_W-1:0]  resp_tag_o;
    logic [1:0]        resp_exc_o;
    logic [1:0]        dbg_state_o;

    ldst_mem_access #(.TAG_W(TAG_W), .TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .addr_i       (addr_i),
        .ldstSize_i   (ldstSize_i),
        .isStore_i    (isStore_i),
        .signed_i     (signed_i),
        .storeData_i  (storeData_i),
        .tag_i        (tag_i),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_be_o     (mem_be_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_ack_i    (mem_ack_i),
        .mem_rdata_i  (mem_rdata_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .resp_data_o  (resp_data_o),
        .resp_tag_o   (resp_tag_o),
        .resp_exc_o   (resp_exc_o),
        .dbg_state_o  (dbg_state_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
        logic [31:0] rdata;
        int          delay;
    } plan_t;

    logic [RESP_W-1:0] exp_q[$];
    int                exp_cyc_q[$];
    plan_t             plan_q[$];
    int                issued = 0;
    int                done_cnt = 0;
    int                next_stall = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int nbytes_of(input int size);
        return (size == 0) ? 1 : (size == 1) ? 2 : 4;
    endfunction

    function automatic int lane_of(input logic [31:0] addr, input int size);
        int n = nbytes_of(size);
        return ((int'(addr % 4)) / n) * n;
    endfunction

    function automatic logic [3:0] ref_be(input logic [31:0] addr, input int size);
        return 4'(((1 << nbytes_of(size)) - 1) << lane_of(addr, size));
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [31:0] sd, input int size);
        int n = nbytes_of(size);
        logic [31:0] piece;
        logic [31:0] r = '0;
        piece = (n == 4) ? sd : (sd & ((32'h1 << (8 * n)) - 1));
        for (int k = 0; k < 4 / n; k++) r = r | (piece << (8 * n * k));
        return r;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] addr, input int size,
                                             input bit sgn, input logic [31:0] rd);
        int n = nbytes_of(size);
        logic [31:0] v;
        logic [31:0] mask;
        v = rd >> (8 * lane_of(addr, size));
        if (n < 4) begin
            mask = (32'h1 << (8 * n)) - 1;
            v = v & mask;
            if (sgn && v[8 * n - 1]) v = v | ~mask;
        end
        return v;
    endfunction

    // ---------------- driver ----------------
    task automatic issue(input logic [31:0] addr, input int size, input bit store, input bit sgn,
                         input logic [31:0] sd, input logic [31:0] rdata, input int delay,
                         input bit wait_done);
        logic [TAG_W-1:0] tag = TAG_W'($urandom);
        bit    trap = 1'b0;
        plan_t p;
        logic [31:0] exp_data;
        logic [1:0]  exp_exc;
        int w = 0;
`ifdef LDST_MISALIGN_TRAP_EN
        trap = (int'(addr % 4) % nbytes_of(size)) != 0;
`endif
        @(negedge clk);
        while (!req_ready_o && w < 200) begin @(negedge clk); w++; end
        check("req_ready_wait", {63'd0, req_ready_o}, 64'd1);
        req_valid_i = 1'b1;
        addr_i      = addr;
        ldstSize_i  = 2'(size);
        isStore_i   = store;
        signed_i    = sgn;
        storeData_i = sd;
        tag_i       = tag;
        if (trap) begin
            exp_data = '0;
            exp_exc  = 2'b01;
            exp_cyc_q.push_back(cyc + 1);
        end else begin
            p.addr  = addr & 32'hFFFF_FFFC;
            p.be    = ref_be(addr, size);
            p.wdata = ref_wdata(sd, size);
            p.we    = store;
            p.rdata = rdata;
            p.delay = delay;
            plan_q.push_back(p);
            exp_exc  = (delay <= TO) ? 2'b00 : 2'b10;
            exp_data = (delay <= TO && !store) ? ref_load(addr, size, sgn, rdata) : 32'd0;
        end
        exp_q.push_back({exp_data, tag, exp_exc});
        issued++;
        @(negedge clk);
        req_valid_i = 1'b0;
        addr_i      = $urandom;
        storeData_i = $urandom;
        tag_i       = TAG_W'($urandom);
        if (wait_done) begin
            w = 0;
            while (done_cnt < issued && w < 300) begin @(negedge clk); w++; end
            check("resp_arrived", 64'(done_cnt), 64'(issued));
            done_cnt = issued;
        end
    endtask

    task automatic check_reset_vals(input string tagname);
        check({tagname, "_req_ready"},  {63'd0, req_ready_o},  64'd1);
        check({tagname, "_mem_req"},    {63'd0, mem_req_o},    64'd0);
        check({tagname, "_mem_be"},     64'(mem_be_o),         64'd0);
        check({tagname, "_resp_valid"}, {63'd0, resp_valid_o}, 64'd0);
        check({tagname, "_resp_exc"},   64'(resp_exc_o),       64'd0);
        check({tagname, "_resp_data"},  64'(resp_data_o),      64'd0);
        check({tagname, "_resp_tag"},   64'(resp_tag_o),       64'd0);
    endtask

    // ---------------- memory responder ----------------
    initial begin
        int    mc = 0;
        plan_t p;
        p = '{addr: 0, be: 0, wdata: 0, we: 0, rdata: 0, delay: 1};
        forever begin
            @(negedge clk);
            if (reset) begin
                mc = 0;
                mem_ack_i = 1'b0;
            end else if (mem_req_o) begin
                mc++;
                if (mc == 1) begin
                    if (plan_q.size() == 0) begin
                        check("mem_req_unexpected", 64'd1, 64'd0);
                        p = '{addr: 0, be: 0, wdata: 0, we: 0, rdata: 0, delay: 1};
                    end else begin
                        p = plan_q.pop_front();
                    end
                end
                check("mem_addr", 64'(mem_addr_o), 64'(p.addr));
                check("mem_be",   64'(mem_be_o),   64'(p.be));
                check("mem_we",   {63'd0, mem_we_o}, {63'd0, p.we});
                if (p.we) check("mem_wdata", 64'(mem_wdata_o), 64'(p.wdata));
                mem_ack_i   = (mc == p.delay);
                mem_rdata_i = mem_ack_i ? p.rdata : $urandom;
                if (mc == p.delay || (p.delay > TO && mc == TO)) exp_cyc_q.push_back(cyc + 1);
            end else begin
                mc = 0;
                // Stray acks outside an access must be ignored.
                mem_ack_i   = ($urandom_range(0, 3) == 0);
                mem_rdata_i = $urandom;
            end
        end
    end

    // ---------------- response monitor ----------------
    initial begin
        bit                in_resp = 1'b0;
        int                stall = 0;
        logic [RESP_W-1:0] held;
        logic [RESP_W-1:0] e;
        forever begin
            @(negedge clk);
            if (reset) begin
                in_resp = 1'b0;
                resp_ready_i = 1'b0;
            end else if (resp_valid_o) begin
                if (!in_resp) begin
                    in_resp = 1'b1;
                    done_cnt++;
                    if (exp_q.size() == 0) begin
                        check("resp_unexpected", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("resp_data", 64'(resp_data_o), 64'(e[RESP_W-1 -: 32]));
                        check("resp_tag",  64'(resp_tag_o),  64'(e[TAG_W+1:2]));
                        check("resp_exc",  64'(resp_exc_o),  64'(e[1:0]));
                    end
                    if (exp_cyc_q.size() == 0) check("resp_latency_missing", 64'd1, 64'd0);
                    else check("resp_latency", 64'(cyc), 64'(exp_cyc_q.pop_front()));
                    held  = {resp_data_o, resp_tag_o, resp_exc_o};
                    stall = (next_stall >= 0) ? next_stall : $urandom_range(0, 3);
                    next_stall = -1;
                end else begin
                    check("resp_stable", 64'({resp_data_o, resp_tag_o, resp_exc_o}), 64'(held));
                end
                check("req_ready_in_resp", {63'd0, req_ready_o}, 64'd0);
                if (stall == 0) resp_ready_i = 1'b1;
                else begin stall--; resp_ready_i = 1'b0; end
            end else begin
                in_resp = 1'b0;
                resp_ready_i = ($urandom_range(0, 1) == 1);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int w;
        int size;
        int delay;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b0;

        issue(32'h0000_1003, 0, 1'b0, 1'b1, 32'h0, 32'h80FF_FFFF, 3, 1'b1);
        issue(32'h0000_1002, 1, 1'b0, 1'b0, 32'h0, 32'h8001_1234, 2, 1'b1);
        issue(32'h0000_2001, 0, 1'b1, 1'b0, 32'h1234_5678, 32'h0, 1, 1'b1);
        issue(32'h0000_3002, 2, 1'b0, 1'b0, 32'h0, 32'hCAFE_F00D, 2, 1'b1);
        issue(32'h0000_4000, 2, 1'b0, 1'b0, 32'h0, 32'h1111_2222, TO + 1, 1'b1);
        issue(32'h0000_4004, 2, 1'b0, 1'b0, 32'h0, 32'h3333_4444, TO, 1'b1);
        next_stall = 5;
        issue(32'h0000_5001, 0, 1'b0, 1'b1, 32'h0, 32'h0000_F200, 1, 1'b1);
        issue(32'h0000_6003, 3, 1'b1, 1'b0, 32'hA5A5_5A5A, 32'h0, 2, 1'b1);

        // Reset in the middle of an access: abandoned with no response.
        issue(32'h0000_7000, 2, 1'b0, 1'b0, 32'h0, 32'h0, 200, 1'b0);
        w = 0;
        while (!mem_req_o && w < 20) begin @(negedge clk); w++; end
        check("mem_req_before_reset", {63'd0, mem_req_o}, 64'd1);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1 check("mem_req_async_drop", {63'd0, mem_req_o}, 64'd0);
        exp_q.delete();
        exp_cyc_q.delete();
        plan_q.delete();
        done_cnt = issued;
        @(negedge clk);
        check_reset_vals("mid_reset");
        @(negedge clk);
        reset = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("no_resp_after_reset", {63'd0, resp_valid_o}, 64'd0);
        end

        for (int i = 0; i < 150; i++) begin
            size  = $urandom_range(0, 3);
            delay = ($urandom_range(0, 19) == 0) ? $urandom_range(TO - 1, TO + 2) : $urandom_range(1, 6);
            issue(32'($urandom), size, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  32'($urandom), 32'($urandom), delay, 1'b1);
        end

        repeat (10) @(negedge clk);
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        check("plan_q_drained", 64'(plan_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/ldst_mem_access.md
LDST_MEM_ACCESS -- requirements
Module: ldst_mem_access

Interface
REQ-001 The block SHALL have parameter TAG_W, default 8, meaning width of the instruction tag carried through.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 64, meaning the maximum number of cycles spent waiting for memory ack.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port req_valid_i, input, 1 bit: a request from the address-generation stage is present.
REQ-006 The block SHALL have port req_ready_o, output, 1 bit: the block accepts a request this cycle.
REQ-007 The block SHALL have port addr_i, input, SIZE_DATA bits: effective byte address.
REQ-008 The block SHALL have port ldstSize_i, input, LDST_TYPES_LOG bits: access size (byte, half word, word).
REQ-009 The block SHALL have port isStore_i, input, 1 bit: 1 = store, 0 = load.
REQ-010 The block SHALL have port signed_i, input, 1 bit: sign-extend load data.
REQ-011 The block SHALL have port storeData_i, input, SIZE_DATA bits: store source data, right-justified.
REQ-012 The block SHALL have port tag_i, input, TAG_W bits: request tag.
REQ-013 The block SHALL have memory-side ports mem_req_o out 1, mem_we_o out 1, mem_addr_o out SIZE_DATA (word-aligned), mem_be_o out 4, mem_wdata_o out SIZE_DATA, mem_ack_i in 1, mem_rdata_i in SIZE_DATA.
REQ-014 The block SHALL have response ports resp_valid_o out 1, resp_ready_i in 1, resp_data_o out SIZE_DATA, resp_tag_o out TAG_W, resp_exc_o out 2 (00 ok, 01 misaligned, 10 timeout).

Function
REQ-015 The FSM SHALL have states IDLE, MEM, RESP; req_ready_o SHALL be 1 only in IDLE.
REQ-016 A request SHALL be accepted when req_valid_i and req_ready_o are both 1: all request fields are registered and the FSM moves to MEM at the next edge.
REQ-017 In MEM: mem_req_o=1, all mem_* outputs held stable; mem_ack_i sampled high SHALL move the FSM to RESP, and the response SHALL be valid the following cycle (ack at cycle M -> resp_valid_o at M+1).
REQ-018 mem_ack_i outside MEM SHALL be ignored.
REQ-019 A wait counter SHALL clear on entry to MEM, increment each MEM cycle, and on reaching TIMEOUT_CYCLES go to RESP with exc=10 and resp_data_o=0; ack in the same cycle as expiry SHALL win (exc=00).
REQ-020 In RESP, resp_valid_o=1 until resp_ready_i=1, then go to IDLE; response fields SHALL be stable while stalled.
REQ-021 Byte lanes are little-endian: byte be=4'b0001<<addr[1:0], wdata=byte replicated x4; half be=4'b0011<<{addr[1],1'b0}, wdata=half replicated x2; word be=4'b1111; ldstSize value 3 SHALL be treated as word.
REQ-022 Load data SHALL be selected from lane addr[1:0] (byte) or addr[1] (half), then zero- or sign-extended per signed_i; stores SHALL return resp_data_o=0.
REQ-023 mem_addr_o SHALL equal {addr[SIZE_DATA-1:2],2'b00}.

Reset
REQ-024 On reset: FSM=IDLE, counter=0, mem_req_o=0, resp_valid_o=0, resp_exc_o=0, resp_data_o=0, resp_tag_o=0, mem_be_o=0.
REQ-025 Reset in MEM or RESP SHALL abandon the access with no response; mem_req_o SHALL drop asynchronously.

Configuration
REQ-026 With LDST_MISALIGN_TRAP_EN defined, a half access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL skip MEM, issue no mem_req_o, and respond the cycle after accept with exc=01.
REQ-027 Without LDST_MISALIGN_TRAP_EN, misaligned low address bits SHALL be ignored (forced alignment) and the access SHALL proceed normally.

Structure
REQ-028 LDST_BYTE=0, LDST_HALF_WORD=1, LDST_WORD=2, the exc codes, and the FSM state encoding SHALL live in the shared package.
REQ-029 Lane select/extension and byte-enable/replication SHALL be a combinational sub-module ldst_lane_align.

Verification
REQ-030 LB addr=0x1003, signed, rdata=0x80FFFFFF, ack 2 cycles after mem_req_o -> resp_data_o=0xFFFFFF80, exc=00, resp at ack+1.
REQ-031 LHU addr=0x1002, rdata=0x8001_1234 -> resp_data_o=0x00008001; mem_addr_o=0x1000.
REQ-032 SB addr=0x2001, storeData=0x12345678 -> mem_we_o=1, mem_be_o=4'b0010, mem_wdata_o=0x78787878.
REQ-033 LW addr=0x3002: with LDST_MISALIGN_TRAP_EN -> no mem_req_o, exc=01; without -> mem_addr_o=0x3000, exc=00.
REQ-034 No ack for 64 cycles -> exc=10, data 0; ack on the 64th cycle -> exc=00; reset asserted in MEM -> mem_req_o=0 immediately, no resp_valid_o.
REQ-035 resp_ready_i=0 for 5 cycles -> resp fields stable, req_ready_o=0 throughout.
